// File: rtl/mii_tx_framer.sv
// MII transmit framer: byte stream in, preamble/SFD + nibble data + zero pad + CRC-32 FCS out,
// followed by an enforced inter-frame gap. Everything runs in the PHY transmit clock domain.
module mii_tx_framer #(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int MIN_FRAME_BYTES  = 60,
  parameter int MAX_FRAME_BYTES  = 1514,
  parameter int IFG_CYCLES       = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid_in,
  input  logic       end_of_frame_in,
  output logic       data_ready_out,
  output logic       phy_tx_en,
  output logic [3:0] phy_tx_data,
  output logic       busy_out,
  output logic       frame_done_out,
  output logic       underrun_out
);
  localparam int CW = $clog2(MAX_FRAME_BYTES + 2);
  localparam int TW = $clog2(PREAMBLE_NIBBLES + IFG_CYCLES + 9);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, DATA_LO, DATA_HI, PAD_LO, PAD_HI, FCS, IFG
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [7:0]      byte_q, byte_d;
  logic            last_q, last_d;
  logic [31:0]     crc_q, crc_d;
  logic [31:0]     fcs_q, fcs_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            tx_en_d, done_d, underrun_d, abort;
  logic [3:0]      txd_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Ready is a pure decode of registered state: no input-to-output path.
  assign data_ready_out = (state_q == SFD) || (state_q == DATA_HI && !last_q);
  assign cnt_inc        = cnt_q + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      tmr_q          <= '0;
      byte_q         <= '0;
      last_q         <= 1'b0;
      crc_q          <= 32'hFFFFFFFF;
      fcs_q          <= '0;
      cnt_q          <= '0;
      phy_tx_en      <= 1'b0;
      phy_tx_data    <= '0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
      underrun_out   <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      byte_q         <= byte_d;
      last_q         <= last_d;
      crc_q          <= crc_d;
      fcs_q          <= fcs_d;
      cnt_q          <= cnt_d;
      phy_tx_en      <= tx_en_d;
      phy_tx_data    <= txd_d;
      busy_out       <= (state_d != IDLE);
      frame_done_out <= done_d;
      underrun_out   <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    byte_d     = byte_q;
    last_d     = last_q;
    crc_d      = crc_q;
    fcs_d      = fcs_q;
    cnt_d      = cnt_q;
    abort      = 1'b0;
    underrun_d = 1'b0;
    tx_en_d    = 1'b0;
    txd_d      = 4'h0;

    case (state_q)
      IDLE: begin
        if (data_valid_in) begin
          state_d = PREAMBLE;
          tmr_d   = '0;
          crc_d   = 32'hFFFFFFFF;
          cnt_d   = '0;
        end
      end
      PREAMBLE: begin
        if (int'(tmr_q) == PREAMBLE_NIBBLES - 1) state_d = SFD;
        else                                      tmr_d   = tmr_q + TW'(1);
      end
      SFD, DATA_HI: begin
        if (state_q == DATA_HI && last_q) begin
          if (int'(cnt_q) < MIN_FRAME_BYTES) begin
            state_d = PAD_LO;
          end else begin
            state_d = FCS;
            tmr_d   = '0;
            fcs_d   = ~crc_q;
          end
        end else if (data_valid_in) begin
          // Byte is consumed even when it overflows the size limit.
          byte_d = data_in;
          last_d = end_of_frame_in;
          crc_d  = crc_byte(crc_q, data_in);
          cnt_d  = cnt_inc;
          if (int'(cnt_inc) > MAX_FRAME_BYTES) abort   = 1'b1;
          else                                 state_d = DATA_LO;
        end else begin
          abort = 1'b1;
        end
      end
      DATA_LO: state_d = DATA_HI;
      PAD_LO:  state_d = PAD_HI;
      PAD_HI: begin
        crc_d = crc_byte(crc_q, 8'h00);
        cnt_d = cnt_inc;
        if (int'(cnt_inc) >= MIN_FRAME_BYTES) begin
          state_d = FCS;
          tmr_d   = '0;
          fcs_d   = ~crc_d;
        end else begin
          state_d = PAD_LO;
        end
      end
      FCS: begin
        if (int'(tmr_q) == 7) begin
          state_d = IFG;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
          fcs_d = fcs_q >> 4;
        end
      end
      IFG: begin
        if (int'(tmr_q) == IFG_CYCLES - 1) begin
          // A waiting frame goes straight to preamble so the gap is exactly IFG_CYCLES.
          if (data_valid_in) begin
            state_d = PREAMBLE;
            tmr_d   = '0;
            crc_d   = 32'hFFFFFFFF;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IFG;
      tmr_d      = '0;
      underrun_d = 1'b1;
    end

    case (state_d)
      PREAMBLE:       begin tx_en_d = 1'b1; txd_d = 4'h5;        end
      SFD:            begin tx_en_d = 1'b1; txd_d = 4'hD;        end
      DATA_LO:        begin tx_en_d = 1'b1; txd_d = byte_d[3:0]; end
      DATA_HI:        begin tx_en_d = 1'b1; txd_d = byte_d[7:4]; end
      PAD_LO, PAD_HI: begin tx_en_d = 1'b1; txd_d = 4'h0;        end
      FCS:            begin tx_en_d = 1'b1; txd_d = fcs_d[3:0];  end
      default:        begin tx_en_d = 1'b0; txd_d = 4'h0;        end
    endcase

    done_d = (state_d == FCS) && (int'(tmr_d) == 7);
  end
endmodule

// File: tb/tb_mii_tx_framer.sv
// Directed bench for mii_tx_framer: one unpadded instance (check vector) and one default instance.
module tb_mii_tx_framer;
  logic       clk, reset;
  logic [7:0] data;
  logic       valid, eof;
  logic       rdy0, en0, busy0, done0, und0;
  logic [3:0] txd0;
  logic       rdy1, en1, busy1, done1, und1;
  logic [3:0] txd1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] frm[$];
  bit         feof[$];

  bit         tr_en[0:399], tr_done[0:399], tr_und[0:399], tr_rdy[0:399], tr_busy[0:399];
  logic [3:0] tr_d[0:399];

  mii_tx_framer #(.MIN_FRAME_BYTES(0)) dut0 (
    .clk(clk), .reset(reset), .data_in(data), .data_valid_in(valid), .end_of_frame_in(eof),
    .data_ready_out(rdy0), .phy_tx_en(en0), .phy_tx_data(txd0), .busy_out(busy0),
    .frame_done_out(done0), .underrun_out(und0));

  mii_tx_framer dut1 (
    .clk(clk), .reset(reset), .data_in(data), .data_valid_in(valid), .end_of_frame_in(eof),
    .data_ready_out(rdy1), .phy_tx_en(en1), .phy_tx_data(txd1), .busy_out(busy1),
    .frame_done_out(done1), .underrun_out(und1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      logic fb;
      fb = r[0] ^ d[b];
      r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  function automatic logic [31:0] model_fcs(input int first, input int n, input int minb);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = crc8(c, frm[first+i]);
    for (int i = n; i < minb; i++) c = crc8(c, 8'h00);
    return ~c;
  endfunction

  function automatic int first_en(input int from);
    for (int i = from; i < 400; i++) if (tr_en[i]) return i;
    return 399;
  endfunction

  function automatic int run_len(input int s);
    int n;
    n = 0;
    while (s + n < 400 && tr_en[s+n]) n++;
    return n;
  endfunction

  function automatic logic [31:0] fcs_obs(input int p);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v = v | (32'(tr_d[p+k]) << (4*k));
    return v;
  endfunction

  function automatic logic [95:0] nibs(input int p, input int n);
    logic [95:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = (v << 4) | 96'(tr_d[p+i]);
    return v;
  endfunction

  // which: 0 done, 1 underrun, 2 ready, 3 tx_en, 4 nonzero txd
  function automatic int cnt(input int which, input int p, input int n);
    int t;
    t = 0;
    for (int i = p; i < p + n && i < 400; i++)
      case (which)
        0: t += int'(tr_done[i]);
        1: t += int'(tr_und[i]);
        2: t += int'(tr_rdy[i]);
        3: t += int'(tr_en[i]);
        default: t += int'(tr_d[i] != 4'h0);
      endcase
    return t;
  endfunction

  task automatic push(input logic [7:0] b, input bit last);
    frm.push_back(b);
    feof.push_back(last);
  endtask

  task automatic load_ascii();
    frm.delete(); feof.delete();
    for (int i = 0; i < 9; i++) push(8'h31 + 8'(i), i == 8);
  endtask

  task automatic idle(input int n);
    valid = 1'b0; eof = 1'b0; data = '0;
    repeat (n) @(negedge clk);
  endtask

  // Host model: presents frm[idx], advances when the selected instance accepted it.
  task automatic run(input bit sel, input int ncyc, input int drop);
    int  idx;
    bit  prev, dropped;
    idx = 0; prev = 1'b0; dropped = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tr_en[i] = 0; tr_done[i] = 0; tr_und[i] = 0; tr_rdy[i] = 0; tr_busy[i] = 0; tr_d[i] = '0;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      tr_en[c]   = sel ? en1   : en0;
      tr_d[c]    = sel ? txd1  : txd0;
      tr_done[c] = sel ? done1 : done0;
      tr_und[c]  = sel ? und1  : und0;
      tr_rdy[c]  = sel ? rdy1  : rdy0;
      tr_busy[c] = sel ? busy1 : busy0;
      if (prev) idx++;
      if (idx == drop) dropped = 1'b1;
      if (!dropped && idx < frm.size()) begin
        valid = 1'b1; data = frm[idx]; eof = feof[idx];
      end else begin
        valid = 1'b0; data = '0; eof = 1'b0;
      end
      prev = (sel ? rdy1 : rdy0) && valid;
    end
  endtask

  initial begin
    int s, s2, l;
    reset = 1'b0; valid = 1'b0; eof = 1'b0; data = '0;
    #12;
    chk("rst_tx_en",  {en1, en0}, '0);
    chk("rst_txd",    {txd1, txd0}, '0);
    chk("rst_busy",   {busy1, busy0}, '0);
    chk("rst_ready",  {rdy1, rdy0}, '0);
    chk("rst_pulses", {done1, und1, done0, und0}, '0);
    @(negedge clk); reset = 1'b1;
    idle(3);

    // Check vector "123456789", no padding
    load_ascii();
    run(0, 90, -1);
    s = first_en(0);
    chk("t1_latency", s, 1);
    chk("t1_len",     run_len(s), 42);
    chk("t1_pre_sfd", nibs(s, 16), 96'h555555555555555D);
    chk("t1_data",    nibs(s + 16, 18), 96'h132333435363738393);
    chk("t1_fcs",     fcs_obs(s + 34), 32'hCBF43926);
    chk("t1_done_at", tr_done[s+41], 1);
    chk("t1_done_n",  cnt(0, 0, 90), 1);
    chk("t1_ifg_en",  cnt(3, s + 42, 24), 0);
    chk("t1_ifg_bsy", tr_busy[s+65], 1);
    chk("t1_idle",    tr_busy[s+66], 0);
    idle(200);

    // Single byte, padded to 60
    frm.delete(); feof.delete(); push(8'hAB, 1);
    run(1, 200, -1);
    s = first_en(0);
    chk("t2_len",  run_len(s), 144);
    chk("t2_data", nibs(s + 16, 2), 96'hBA);
    chk("t2_pad",  cnt(4, s + 18, 118), 0);
    chk("t2_fcs",  fcs_obs(s + 136), model_fcs(0, 1, 60));
    chk("t2_done", tr_done[s+143], 1);
    idle(200);

    // 64-byte frame, valid always available
    frm.delete(); feof.delete();
    for (int i = 0; i < 64; i++) push(8'(i * 7 + 3), i == 63);
    run(1, 220, -1);
    s = first_en(0);
    chk("t3_len",     run_len(s), 152);
    chk("t3_rdy_n",   cnt(2, 0, 220), 64);
    chk("t3_rdy_sfd", tr_rdy[s+15], 1);
    chk("t3_fcs",     fcs_obs(s + 144), model_fcs(0, 64, 60));
    idle(200);

    // Underrun on the 10th byte's high nibble
    frm.delete(); feof.delete();
    for (int i = 0; i < 20; i++) push(8'(i + 1), i == 19);
    run(1, 100, 10);
    s = first_en(0);
    chk("t4_len",    run_len(s), 36);
    chk("t4_und_at", tr_und[s+36], 1);
    chk("t4_und_n",  cnt(1, 0, 100), 1);
    chk("t4_done_n", cnt(0, 0, 100), 0);
    chk("t4_ifg",    tr_busy[s+59], 1);
    chk("t4_idle",   tr_busy[s+60], 0);
    idle(200);
    load_ascii();
    run(1, 200, -1);
    s = first_en(0);
    chk("t4b_len", run_len(s), 144);
    chk("t4b_fcs", fcs_obs(s + 136), model_fcs(0, 9, 60));
    idle(200);

    // Back-to-back frames, valid held through the gap
    frm.delete(); feof.delete();
    push(8'h10, 0); push(8'h20, 0); push(8'h30, 1);
    push(8'hA1, 0); push(8'hB2, 0); push(8'hC3, 1);
    run(0, 120, -1);
    s  = first_en(0);
    l  = run_len(s);
    s2 = first_en(s + l);
    chk("t5_len1", l, 30);
    chk("t5_gap",  s2 - (s + l), 24);
    chk("t5_len2", run_len(s2), 30);
    chk("t5_fcs1", fcs_obs(s + 22), model_fcs(0, 3, 0));
    chk("t5_fcs2", fcs_obs(s2 + 22), model_fcs(3, 3, 0));
    idle(200);

    // Reset asserted in mid-frame
    load_ascii();
    run(1, 31, -1);
    chk("t6_pre_en", tr_en[30], 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_en",     en1, 0);
    chk("t6_rst_txd",    txd1, 0);
    chk("t6_rst_busy",   busy1, 0);
    chk("t6_rst_pulses", {done1, und1}, '0);
    valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    idle(5);
    run(1, 200, -1);
    s = first_en(0);
    chk("t6_latency", s, 1);
    chk("t6_pre_sfd", nibs(s, 16), 96'h555555555555555D);
    chk("t6_len",     run_len(s), 144);
    chk("t6_fcs",     fcs_obs(s + 136), model_fcs(0, 9, 60));
    idle(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mii_tx_framer.md
Name: mii_tx_framer

Overview:
- Transmit-side MII framer: accepts a frame as a byte stream from the host side (valid / end-of-frame / ready) and drives the PHY MII transmit pins.
- Generates preamble and SFD, sends data low nibble first, zero-pads to the minimum frame size, appends CRC-32 FCS, then enforces the inter-frame gap.
- Complements the MII receive path; runs entirely in the PHY transmit clock domain.

Parameters:
- PREAMBLE_NIBBLES, 15, number of 0x5 nibbles sent before the final SFD nibble 0xD.
- MIN_FRAME_BYTES, 60, minimum DA..payload byte count before FCS; shorter frames are zero-padded. 0 disables padding.
- MAX_FRAME_BYTES, 1514, maximum accepted bytes; exceeding this aborts the frame.
- IFG_CYCLES, 24, clocks with phy_tx_en low after the FCS (12 byte times).

Ports:
- clk  in  1  MII transmit clock (phy_tx_clk, 25 MHz at 100 Mbit/s).
- reset  in  1  asynchronous, active-low reset.
- data_in  in  8  frame byte (destination MAC first).
- data_valid_in  in  1  data_in holds a valid byte.
- end_of_frame_in  in  1  qualifies data_in as the last byte of the frame.
- data_ready_out  out  1  byte accepted at this edge when data_valid_in=1.
- phy_tx_en  out  1  MII TX_EN.
- phy_tx_data  out  4  MII TXD.
- busy_out  out  1  high in every state except IDLE.
- frame_done_out  out  1  one-cycle pulse on the last FCS nibble.
- underrun_out  out  1  one-cycle pulse when a frame is aborted (underrun or oversize).

Behaviour:
- Reset (async, reset=0): state IDLE; phy_tx_en=0, phy_tx_data=0, data_ready_out=0, busy_out=0, pulses=0, CRC=0xFFFFFFFF, byte count=0.
- phy_tx_en, phy_tx_data, busy_out, frame_done_out and underrun_out are registered. data_ready_out is decoded from registered state with no combinational path from inputs.
- States: IDLE, PREAMBLE, SFD, DATA_LO, DATA_HI, PAD_LO, PAD_HI, FCS, IFG.
- IDLE: data_valid_in=1 at edge k -> PREAMBLE; phy_tx_en=1, txd=0x5 from edge k+1. The byte is not consumed.
- PREAMBLE: PREAMBLE_NIBBLES cycles of 0x5, then SFD.
- SFD: one cycle of 0xD with data_ready_out=1.
  - Valid at the SFD edge -> load byte register, CRC update, count=1, go to DATA_LO.
  - Not valid -> abort.
- DATA_LO: txd=byte[3:0] -> DATA_HI.
- DATA_HI: txd=byte[7:4].
  - If the current byte was not last: data_ready_out=1. Valid -> load next byte, CRC update, count+1, DATA_LO. Not valid -> abort.
  - If last: count<MIN_FRAME_BYTES -> PAD_LO, else FCS. data_ready_out=0.
- Oversize: acceptance that would make count>MAX_FRAME_BYTES -> abort (the byte is still consumed).
- PAD_LO/PAD_HI: txd=0x0; CRC updated with 0x00 once per pad byte; count+1 per byte. Loop until count==MIN_FRAME_BYTES, then FCS.
- FCS: fcs=~crc, 8 cycles; txd = fcs[3:0], fcs[7:4], …, fcs[31:28]. frame_done_out=1 on the 8th cycle. Then IFG.
- CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, byte-wise LSB-first update over DA..pad. Reinitialised on entering PREAMBLE.
- Abort: next cycle phy_tx_en=0, txd=0, underrun_out=1 pulse, go to IFG. No FCS is sent, so the far end sees a CRC error.
- Abort mid-frame: no more bytes are consumed. The host must drop the rest of the frame itself; the block does not flush it.
- IFG: phy_tx_en=0, txd=0 for IFG_CYCLES cycles, then IDLE.
  - data_ready_out=0 throughout.
  - A valid already pending at IFG exit starts the next preamble on the following edge.
- Latency: IDLE-detect to first preamble nibble is 1 cycle. Preamble+SFD is PREAMBLE_NIBBLES+1 cycles. Each byte is 2 cycles.
- end_of_frame_in is ignored unless accepted with a byte. A single-byte frame is valid (eof with the SFD-cycle byte).
- Reset asserted mid-frame: outputs go to reset values immediately (async); no FCS and no pulse.

Test Plan:
- MIN_FRAME_BYTES=0; send ASCII "123456789" with eof on '9'.
  - TXD = 15×0x5, 0xD, then 1,3,2,3,…,9,3.
  - FCS nibbles 6,2,9,3,4,F,B,C (0xCBF43926).
  - tx_en high for 42 cycles; frame_done pulse on the C nibble.
  - Then 24 cycles tx_en=0.
- Default parameters; 1-byte frame 0xAB.
  - Data B,A, then 59 zero-pad bytes (118 nibbles 0x0), then 8 FCS nibbles matching the bench CRC model.
  - Total tx_en-high cycles = 16+120+8 = 144.
- 64-byte frame with data_valid_in held high.
  - data_ready_out high exactly 64 cycles, on the SFD cycle then every DATA_HI except the last.
  - No padding; FCS matches the model.
- Drop data_valid_in during DATA_HI of byte 10.
  - Next cycle: tx_en=0, underrun_out pulses once, no FCS.
  - IDLE after 24 IFG cycles; a following frame transmits correctly.
- Back-to-back frames with valid held high after eof: exactly 24 tx_en-low cycles between the last FCS nibble and the first preamble nibble of frame 2.
- Assert reset at nibble 30 of a frame: tx_en=0, txd=0, busy_out=0 immediately. After release, a new frame starts with full preamble and correct CRC.
